// File: rtl/aqp_esp_pkg.sv
// Shared definitions for the ESP32 SPI command decoder: opcodes, state encoding
// and default parameter values.
package aqp_esp_pkg;

    localparam int         ADDR_W_DEFAULT  = 19;
    localparam logic [7:0] TX_IDLE_DEFAULT = 8'h00;

    localparam logic [7:0] CMD_WRITE_MEM = 8'h10;
    localparam logic [7:0] CMD_READ_MEM  = 8'h11;
    localparam logic [7:0] CMD_WRITE_REG = 8'h20;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR0,
        ST_ADDR1,
        ST_ADDR2,
        ST_WDATA,
        ST_RDATA,
        ST_REG_IDX,
        ST_REG_VAL,
        ST_DISCARD
    } state_e;

endpackage

// File: rtl/aqp_esp_busreq.sv
// Bus request holder: keeps req/wr/addr/data stable until ack and parks one
// request that arrives while a transfer is still in flight.
module aqp_esp_busreq
    import aqp_esp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic              start_wr_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [7:0]        start_data_i,
    input  logic              bus_ack_i,
    output logic              bus_req_o,
    output logic              bus_wr_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [7:0]        bus_wrdata_o,
    output logic              pend_o
);

    logic              req_q, req_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              pend_q, pend_d;
    logic              pwr_q, pwr_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [7:0]        pdata_q, pdata_d;

    always_comb begin
        req_d   = req_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        pend_d  = pend_q;
        pwr_d   = pwr_q;
        paddr_d = paddr_q;
        pdata_d = pdata_q;
        if (req_q && bus_ack_i) begin
            req_d = 1'b0;
        end
        // A parked request launches only after req has been low for a cycle.
        if (!req_q && pend_q) begin
            req_d  = 1'b1;
            wr_d   = pwr_q;
            addr_d = paddr_q;
            data_d = pdata_q;
            pend_d = 1'b0;
        end
        if (start_i) begin
            if (req_q || pend_q) begin
                pend_d  = 1'b1;
                pwr_d   = start_wr_i;
                paddr_d = start_addr_i;
                pdata_d = start_data_i;
            end else begin
                req_d  = 1'b1;
                wr_d   = start_wr_i;
                addr_d = start_addr_i;
                data_d = start_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            pend_q  <= 1'b0;
            pwr_q   <= 1'b0;
            paddr_q <= '0;
            pdata_q <= '0;
        end else begin
            req_q   <= req_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            pwr_q   <= pwr_d;
            paddr_q <= paddr_d;
            pdata_q <= pdata_d;
        end
    end

    assign bus_req_o    = req_q;
    assign bus_wr_o     = wr_q;
    assign bus_addr_o   = addr_q;
    assign bus_wrdata_o = data_q;
    assign pend_o       = pend_q;

endmodule

// File: rtl/aqp_esp_cmd.sv
// Command decoder behind the ESP32 SPI slave: decodes memory write/read bursts
// and register writes from the received byte stream and feeds the readback byte.
module aqp_esp_cmd
    import aqp_esp_pkg::*;
#(
    parameter int         ADDR_W  = ADDR_W_DEFAULT,
    parameter logic [7:0] TX_IDLE = TX_IDLE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              msg_start,
    input  logic              msg_end,
    input  logic [7:0]        rxdata,
    input  logic              rxdata_valid,
    output logic [7:0]        txdata,
    input  logic              txdata_ack,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wrdata,
    input  logic [7:0]        bus_rddata,
    input  logic              bus_ack,
    output logic              reg_wr,
    output logic [7:0]        reg_idx,
    output logic [7:0]        reg_data,
    output logic              overrun
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cmd_rd_q, cmd_rd_d;
    logic [7:0]        txdata_q, txdata_d;
    logic              overrun_q, overrun_d;
    logic              reg_wr_q, reg_wr_d;
    logic [7:0]        reg_idx_q, reg_idx_d;
    logic [7:0]        reg_data_q, reg_data_d;
    logic              start, start_wr, pend;
    logic [ADDR_W-1:0] start_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cmd_rd_q   <= 1'b0;
            txdata_q   <= TX_IDLE;
            overrun_q  <= 1'b0;
            reg_wr_q   <= 1'b0;
            reg_idx_q  <= '0;
            reg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cmd_rd_q   <= cmd_rd_d;
            txdata_q   <= txdata_d;
            overrun_q  <= overrun_d;
            reg_wr_q   <= reg_wr_d;
            reg_idx_q  <= reg_idx_d;
            reg_data_q <= reg_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rxdata_valid) begin
            unique case (state_q)
                ST_CMD: begin
                    if (rxdata == CMD_WRITE_MEM || rxdata == CMD_READ_MEM) state_d = ST_ADDR0;
                    else if (rxdata == CMD_WRITE_REG)                      state_d = ST_REG_IDX;
                    else                                                   state_d = ST_DISCARD;
                end
                ST_ADDR0:   state_d = ST_ADDR1;
                ST_ADDR1:   state_d = ST_ADDR2;
                ST_ADDR2:   state_d = cmd_rd_q ? ST_RDATA : ST_WDATA;
                ST_REG_IDX: state_d = ST_REG_VAL;
                ST_REG_VAL: state_d = ST_DISCARD;
                default:    state_d = state_q;
            endcase
        end
        if (msg_end)   state_d = ST_IDLE;
        if (msg_start) state_d = ST_CMD;
    end

    always_comb begin
        addr_d     = addr_q;
        cmd_rd_d   = cmd_rd_q;
        txdata_d   = txdata_q;
        overrun_d  = overrun_q;
        reg_wr_d   = 1'b0;
        reg_idx_d  = reg_idx_q;
        reg_data_d = reg_data_q;
        start      = 1'b0;
        start_wr   = 1'b0;
        start_addr = addr_q;
        if (msg_start) begin
            overrun_d = 1'b0;
            txdata_d  = TX_IDLE;
        end else begin
            if (rxdata_valid) begin
                unique case (state_q)
                    ST_CMD:   cmd_rd_d = (rxdata == CMD_READ_MEM);
                    ST_ADDR0: addr_d[7:0]  = rxdata;
                    ST_ADDR1: addr_d[15:8] = rxdata;
                    ST_ADDR2: begin
                        addr_d[ADDR_W-1:16] = rxdata[ADDR_W-17:0];
                        if (cmd_rd_q) begin
                            start      = 1'b1;
                            start_addr = addr_d;
                        end
                    end
                    ST_WDATA: begin
                        // The ack cycle frees the bus, so a byte landing then is parked, not dropped.
                        if (pend || (bus_req && !bus_ack)) begin
                            overrun_d = 1'b1;
                        end else begin
                            start    = 1'b1;
                            start_wr = 1'b1;
                            addr_d   = addr_q + 1'b1;
                        end
                    end
                    ST_REG_IDX: reg_idx_d = rxdata;
                    ST_REG_VAL: begin
                        reg_data_d = rxdata;
                        reg_wr_d   = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (state_q == ST_RDATA && txdata_ack && !msg_end) begin
                if (bus_req || pend) begin
                    overrun_d = 1'b1;
                end else begin
                    addr_d     = addr_q + 1'b1;
                    start      = 1'b1;
                    start_addr = addr_d;
                end
            end
            if (state_q == ST_RDATA && bus_req && bus_ack && !bus_wr) begin
                txdata_d = bus_rddata;
            end
        end
    end

    aqp_esp_busreq #(.ADDR_W(ADDR_W)) u_busreq (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_i      (start),
        .start_wr_i   (start_wr),
        .start_addr_i (start_addr),
        .start_data_i (rxdata),
        .bus_ack_i    (bus_ack),
        .bus_req_o    (bus_req),
        .bus_wr_o     (bus_wr),
        .bus_addr_o   (bus_addr),
        .bus_wrdata_o (bus_wrdata),
        .pend_o       (pend)
    );

    assign txdata   = txdata_q;
    assign overrun  = overrun_q;
    assign reg_wr   = reg_wr_q;
    assign reg_idx  = reg_idx_q;
    assign reg_data = reg_data_q;

endmodule

// File: tb/tb_aqp_esp_cmd.sv
// Bench for aqp_esp_cmd: SPI byte-stream driver, bus slave with memory model,
// and per-feature scenario tasks.
module tb_aqp_esp_cmd;
  import aqp_esp_pkg::*;

  localparam int AW = 19;
  localparam int AMOD = 1 << AW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic msg_start = 1'b0, msg_end = 1'b0, rxdata_valid = 1'b0, txdata_ack = 1'b0;
  logic [7:0] rxdata = 8'h00;
  logic [7:0] txdata;
  logic bus_req, bus_wr, bus_ack, reg_wr, overrun;
  logic [AW-1:0] bus_addr;
  logic [7:0] bus_wrdata, bus_rddata, reg_idx, reg_data;

  // Handshake: bus_req/bus_wr/bus_addr/bus_wrdata hold steady from rise until the
  // cycle bus_ack is seen; bus_ack is a one-cycle pulse with bus_rddata valid.

  always #5 clk = ~clk;

  aqp_esp_cmd #(.ADDR_W(AW), .TX_IDLE(8'h00)) dut (
    .clk(clk), .reset_n(reset_n), .msg_start(msg_start), .msg_end(msg_end),
    .rxdata(rxdata), .rxdata_valid(rxdata_valid), .txdata(txdata), .txdata_ack(txdata_ack),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wrdata(bus_wrdata),
    .bus_rddata(bus_rddata), .bus_ack(bus_ack), .reg_wr(reg_wr), .reg_idx(reg_idx),
    .reg_data(reg_data), .overrun(overrun)
  );

  int errors = 0;
  int checks = 0;
  logic [AW+7:0] exp_q[$];
  logic [AW+7:0] act_q[$];
  logic [7:0] mem [int];
  int ack_delay = 2;
  int xfer_cnt = 0;
  int proto_err = 0;
  bit in_xfer = 1'b0;
  bit req_prev = 1'b0;
  int reg_cnt = 0;
  logic [7:0] reg_idx_seen = 8'h00, reg_data_seen = 8'h00;

  function automatic logic [7:0] mem_rd(int a);
    if (mem.exists(a)) return mem[a];
    return 8'(a) ^ 8'h5A;
  endfunction

  // Bus slave: answers each request after ack_delay cycles and logs writes.
  initial begin
    logic [AW-1:0] x_addr;
    logic x_wr;
    logic [7:0] x_data;
    int cnt;
    bus_ack = 1'b0;
    bus_rddata = 8'h00;
    x_addr = '0; x_wr = 1'b0; x_data = 8'h00; cnt = 0;
    forever begin
      @(posedge clk); #2;
      bus_ack = 1'b0;
      if (!reset_n) begin
        in_xfer = 1'b0;
        req_prev = 1'b0;
      end else begin
        if (!in_xfer && bus_req === 1'b1) begin
          if (req_prev) proto_err++;
          in_xfer = 1'b1; cnt = ack_delay;
          x_addr = bus_addr; x_wr = bus_wr; x_data = bus_wrdata;
          xfer_cnt++;
        end else if (in_xfer && (bus_req !== 1'b1 || bus_addr !== x_addr ||
                                 bus_wr !== x_wr || bus_wrdata !== x_data)) begin
          proto_err++;
        end
        if (in_xfer) begin
          if (cnt == 0) begin
            bus_ack = 1'b1;
            bus_rddata = x_wr ? 8'h00 : mem_rd(int'(x_addr));
            if (x_wr) begin
              mem[int'(x_addr)] = x_data;
              act_q.push_back({x_addr, x_data});
            end
            in_xfer = 1'b0;
          end else begin
            cnt--;
          end
        end
        req_prev = (bus_req === 1'b1);
      end
    end
  end

  always @(negedge clk) begin
    if (reg_wr === 1'b1) begin
      reg_cnt++;
      reg_idx_seen = reg_idx;
      reg_data_seen = reg_data;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic p_start();
    msg_start = 1'b1; tick(); msg_start = 1'b0;
  endtask

  task automatic p_end();
    msg_end = 1'b1; tick(); msg_end = 1'b0;
  endtask

  task automatic p_txack();
    txdata_ack = 1'b1; tick(); txdata_ack = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b, int gap);
    rxdata = b; rxdata_valid = 1'b1; tick(); rxdata_valid = 1'b0; tick(gap);
  endtask

  task automatic wait_bus_idle(int budget, string name);
    int n = 0;
    while ((bus_req === 1'b1 || in_xfer) && n < budget) begin tick(); n++; end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: bus still busy after %0d cycles, required idle", name, budget);
    end
    tick(3);
  endtask

  // Reference: a burst from a 24-bit wire address lands at consecutive addresses mod 2^AW.
  task automatic model_write(int a24, logic [7:0] d[$]);
    for (int i = 0; i < d.size(); i++) exp_q.push_back({AW'((a24 + i) % AMOD), d[i]});
  endtask

  task automatic test_reset();
    tick(3);
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req: got %b want 0", bus_req); end
    checks++; if (bus_wr !== 1'b0) begin errors++; $display("FAIL rst_bus_wr: got %b want 0", bus_wr); end
    checks++; if (bus_addr !== '0) begin errors++; $display("FAIL rst_bus_addr: got %h want 0", bus_addr); end
    checks++; if (txdata !== 8'h00) begin errors++; $display("FAIL rst_txdata: got %h want 00", txdata); end
    checks++; if ({reg_wr, reg_idx, reg_data, overrun} !== 18'h0) begin
      errors++; $display("FAIL rst_reg_ovr: got %b/%h/%h/%b want 0", reg_wr, reg_idx, reg_data, overrun);
    end
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_write_mem();
    logic [7:0] d[$];
    int a;
    int n;
    exp_q.delete(); act_q.delete();
    ack_delay = 2;
    p_start();
    send_byte(8'h10, 3); send_byte(8'h34, 3); send_byte(8'h12, 3); send_byte(8'h00, 3);
    send_byte(8'hAA, 8); send_byte(8'hBB, 8);
    p_end();
    wait_bus_idle(50, "wr_dir_idle");
    d = '{8'hAA, 8'hBB};
    model_write(24'h001234, d);
    for (int k = 0; k < 4; k++) begin
      a = (k == 0) ? 24'h07FFFE : int'($urandom_range(0, 24'hFFFFFF));
      n = $urandom_range(2, 5);
      ack_delay = $urandom_range(0, 4);
      d.delete();
      for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, 255)));
      p_start();
      send_byte(8'h10, 3);
      send_byte(8'(a), 3); send_byte(8'(a >> 8), 3); send_byte(8'(a >> 16), 3);
      for (int i = 0; i < n; i++) send_byte(d[i], 8);
      p_end();
      wait_bus_idle(50, "wr_rnd_idle");
      model_write(a, d);
    end
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL wr_count: got %0d writes want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL wr_entry%0d: got addr/data %h want %h", i, act_q[i], exp_q[i]);
      end
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL wr_overrun: got %b want 0", overrun); end
  endtask

  task automatic read_burst(int a, int n, string name);
    logic [7:0] want;
    p_start();
    checks++; if (txdata !== 8'h00) begin errors++; $display("FAIL %s_idle: got %h want 00", name, txdata); end
    send_byte(8'h11, 3);
    send_byte(8'(a), 3); send_byte(8'(a >> 8), 3); send_byte(8'(a >> 16), 10);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin p_txack(); tick(10); end
      want = mem_rd((a + i) % AMOD);
      checks++;
      if (txdata !== want) begin
        errors++; $display("FAIL %s_byte%0d: got %h want %h", name, i, txdata, want);
      end
    end
    p_end();
    wait_bus_idle(50, {name, "_idle"});
  endtask

  task automatic test_read_mem();
    mem[32'h7FFFF] = 8'h5A; mem[0] = 8'hC3; mem[1] = 8'h99;
    ack_delay = 3;
    read_burst(24'h07FFFF, 3, "rd_wrap");
    ack_delay = $urandom_range(0, 4);
    read_burst(int'($urandom_range(0, 24'hFFFFFF)), 3, "rd_rnd");
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rd_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_write_reg();
    int r0 = reg_cnt;
    int x0 = xfer_cnt;
    logic [7:0] ri = 8'($urandom_range(0, 255));
    logic [7:0] rv = 8'($urandom_range(0, 255));
    p_start();
    send_byte(8'h20, 3); send_byte(8'h05, 3); send_byte(8'h7E, 3); send_byte(8'h01, 3);
    p_end(); tick(3);
    checks++; if (reg_cnt - r0 != 1) begin errors++; $display("FAIL reg_pulses: got %0d want 1", reg_cnt - r0); end
    checks++; if (reg_idx_seen !== 8'h05) begin errors++; $display("FAIL reg_idx: got %h want 05", reg_idx_seen); end
    checks++; if (reg_data_seen !== 8'h7E) begin errors++; $display("FAIL reg_data: got %h want 7E", reg_data_seen); end
    p_start();
    send_byte(8'h20, 2); send_byte(ri, 2); send_byte(rv, 2);
    p_end(); tick(3);
    checks++; if (reg_cnt - r0 != 2) begin errors++; $display("FAIL reg_rnd_pulses: got %0d want 2", reg_cnt - r0); end
    checks++; if ({reg_idx_seen, reg_data_seen} !== {ri, rv}) begin
      errors++; $display("FAIL reg_rnd_val: got %h/%h want %h/%h", reg_idx_seen, reg_data_seen, ri, rv);
    end
    checks++; if (xfer_cnt != x0) begin errors++; $display("FAIL reg_no_bus: got %0d xfers want 0", xfer_cnt - x0); end
  endtask

  task automatic test_overrun();
    act_q.delete();
    ack_delay = 50;
    p_start();
    send_byte(8'h10, 3); send_byte(8'h00, 3); send_byte(8'h01, 3); send_byte(8'h00, 3);
    send_byte(8'hA1, 9); send_byte(8'hB2, 2);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
    wait_bus_idle(100, "ovr_idle");
    checks++; if (act_q.size() != 1) begin errors++; $display("FAIL ovr_count: got %0d writes want 1", act_q.size()); end
    else begin
      checks++; if (act_q[0] !== {AW'(32'h00100), 8'hA1}) begin
        errors++; $display("FAIL ovr_entry: got %h want %h", act_q[0], {AW'(32'h00100), 8'hA1});
      end
    end
    p_end(); tick();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    p_start(); tick();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    p_end(); tick(2);
  endtask

  task automatic test_msg_end_mid();
    int x0;
    int r0;
    act_q.delete();
    ack_delay = 20;
    x0 = xfer_cnt;
    p_start();
    send_byte(8'h10, 3); send_byte(8'h20, 3); send_byte(8'h00, 3); send_byte(8'h00, 3);
    send_byte(8'hC5, 0);
    tick(1);
    p_end();
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL end_req_held: got %b want 1", bus_req); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL end_state: got %0d want IDLE", dut.state_q); end
    send_byte(8'hD6, 3);
    wait_bus_idle(60, "end_idle");
    tick(30);
    checks++; if (xfer_cnt - x0 != 1) begin errors++; $display("FAIL end_xfers: got %0d want 1", xfer_cnt - x0); end
    checks++; if (act_q.size() != 1 || act_q[0] !== {AW'(32'h00020), 8'hC5}) begin
      errors++; $display("FAIL end_entry: got %0d writes want one at 00020", act_q.size());
    end
    r0 = reg_cnt;
    p_start();
    send_byte(8'h20, 2); send_byte(8'h33, 2); send_byte(8'h44, 2);
    p_end(); tick(3);
    checks++; if (reg_cnt - r0 != 1 || reg_idx_seen !== 8'h33 || reg_data_seen !== 8'h44) begin
      errors++; $display("FAIL end_next_cmd: got %0d/%h/%h want 1/33/44", reg_cnt - r0, reg_idx_seen, reg_data_seen);
    end
  endtask

  task automatic test_discard();
    int x0 = xfer_cnt;
    int r0 = reg_cnt;
    ack_delay = 2;
    p_start();
    send_byte(8'h55, 3); send_byte(8'h10, 3); send_byte(8'h11, 3); send_byte(8'h20, 3); send_byte(8'h01, 3);
    checks++; if (txdata !== 8'h00) begin errors++; $display("FAIL disc_txdata: got %h want 00", txdata); end
    p_end(); tick(5);
    checks++; if (xfer_cnt != x0 || reg_cnt != r0) begin
      errors++; $display("FAIL disc_activity: got %0d xfers %0d regs want 0 0", xfer_cnt - x0, reg_cnt - r0);
    end
  endtask

  task automatic test_read_overrun();
    logic [7:0] want;
    ack_delay = 15;
    p_start();
    send_byte(8'h11, 2); send_byte(8'h00, 2); send_byte(8'h02, 2); send_byte(8'h00, 1);
    p_txack(); tick();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL rdovr_set: got %b want 1", overrun); end
    wait_bus_idle(60, "rdovr_idle");
    want = mem_rd(32'h00200);
    checks++; if (txdata !== want) begin errors++; $display("FAIL rdovr_data: got %h want %h", txdata, want); end
    p_end(); tick(2);
  endtask

  task automatic test_reset_mid_read();
    ack_delay = 30;
    p_start();
    send_byte(8'h11, 2); send_byte(8'h40, 2); send_byte(8'h00, 2); send_byte(8'h00, 2);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b want 1", bus_req); end
    reset_n = 1'b0;
    #1;
    checks++; if ({bus_req, bus_wr, bus_addr, bus_wrdata} !== '0) begin
      errors++; $display("FAIL rstmid_bus: got %b/%b/%h/%h want 0", bus_req, bus_wr, bus_addr, bus_wrdata);
    end
    checks++; if ({txdata, overrun, reg_wr, reg_idx, reg_data} !== '0) begin
      errors++; $display("FAIL rstmid_out: got %h/%b/%b/%h/%h want 0", txdata, overrun, reg_wr, reg_idx, reg_data);
    end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL rstmid_state: got %0d want IDLE", dut.state_q); end
    tick(3);
    reset_n = 1'b1;
    tick(3);
  endtask

  task automatic test_protocol();
    checks++;
    if (proto_err != 0) begin errors++; $display("FAIL bus_protocol: got %0d violations want 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_write_mem();
    test_read_mem();
    test_write_reg();
    test_overrun();
    test_msg_end_mid();
    test_discard();
    test_read_overrun();
    test_reset_mid_read();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
